// File: rtl/fcmp_pipe_if.sv
// Operand/result handshake bundle for fcmp_pipe: the producer side uses master, the compare unit uses slave.
interface fcmp_pipe_if #(
    parameter int EW = 8,
    parameter int MW = 23
);
    localparam int W = 1 + EW + MW;

    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] x1;
    logic [W-1:0] x2;
    logic         out_valid;
    logic         out_ready;
    logic         y;
    logic         unord;

    modport master (
        output in_valid, op, x1, x2, out_ready,
        input  in_ready, out_valid, y, unord
    );

    modport slave (
        input  in_valid, op, x1, x2, out_ready,
        output in_ready, out_valid, y, unord
    );
endinterface

// File: rtl/fcmp_pipe.sv
// Pipelined flush-to-zero floating-point compare (LT/LE/EQ) with valid/ready backpressure.
// Optional NaN detection and the unord output are enabled by defining FCMP_NAN_EN.
module fcmp_pipe #(
    parameter int EW     = 8,
    parameter int MW     = 23,
    parameter int STAGES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    fcmp_pipe_if.slave bus
);
    localparam int W    = 1 + EW + MW;
    localparam int MAGW = EW + MW;

    typedef struct packed {
        logic [1:0] op;
        logic       s1;
        logic       s2;
        logic       gt;
        logic       eq;
`ifdef FCMP_NAN_EN
        logic       un;
`endif
    } dec_t;

`ifdef FCMP_NAN_EN
    function automatic logic is_nan(input logic [W-1:0] x);
        return (&x[W-2 -: EW]) && (|x[MW-1:0]);
    endfunction
`endif

    // Zero-class operands collapse to +0 so that sign resolution never sees a signed zero.
    function automatic dec_t decode(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        dec_t            d;
        logic            za;
        logic            zb;
        logic [MAGW-1:0] ma;
        logic [MAGW-1:0] mb;
        za   = ~|a[W-2 -: EW];
        zb   = ~|b[W-2 -: EW];
        ma   = za ? '0 : a[MAGW-1:0];
        mb   = zb ? '0 : b[MAGW-1:0];
        d.op = op;
        d.s1 = a[W-1] & ~za;
        d.s2 = b[W-1] & ~zb;
        d.gt = (ma > mb);
        d.eq = (ma == mb);
`ifdef FCMP_NAN_EN
        d.un = (op != 2'b11) && (is_nan(a) || is_nan(b));
`endif
        return d;
    endfunction

    function automatic logic resolve(input dec_t d);
        logic lt;
        logic eq;
        logic y;
        eq = (d.s1 == d.s2) && d.eq;
        if (d.s1 != d.s2)
            lt = d.s1;
        else if (d.s1)
            lt = d.gt;
        else
            lt = ~d.gt & ~d.eq;
        case (d.op)
            2'b00:   y = lt;
            2'b01:   y = lt | eq;
            2'b10:   y = eq;
            default: y = 1'b0;
        endcase
`ifdef FCMP_NAN_EN
        if (d.un)
            y = 1'b0;
`endif
        return y;
    endfunction

    logic w_en;
    dec_t w_dec_p0;
    logic w_vld_p0;
    dec_t w_dec_fin;
    logic w_vld_fin;
    logic r_out_vld;
    logic r_y;

    assign w_en         = ~r_out_vld | bus.out_ready;
    assign bus.in_ready = w_en;

    // Stage 1: decode, flush and magnitude compare.
    assign w_vld_p0 = bus.in_valid;
    assign w_dec_p0 = decode(bus.op, bus.x1, bus.x2);

    generate
        if (STAGES == 1) begin : g_nodly
            assign w_dec_fin = w_dec_p0;
            assign w_vld_fin = w_vld_p0;
        end else begin : g_dly
            dec_t r_dec_p [1:STAGES-1];
            logic r_vld_p [1:STAGES-1];

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int k = 1; k < STAGES; k++)
                        r_vld_p[k] <= 1'b0;
                end else if (w_en) begin
                    r_vld_p[1] <= w_vld_p0;
                    for (int k = 2; k < STAGES; k++)
                        r_vld_p[k] <= r_vld_p[k-1];
                end
            end

            always_ff @(posedge clk) begin
                if (w_en) begin
                    r_dec_p[1] <= w_dec_p0;
                    for (int k = 2; k < STAGES; k++)
                        r_dec_p[k] <= r_dec_p[k-1];
                end
            end

            assign w_dec_fin = r_dec_p[STAGES-1];
            assign w_vld_fin = r_vld_p[STAGES-1];
        end
    endgenerate

    // Final stage: sign resolution and op mux into the output register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_vld <= 1'b0;
            r_y       <= 1'b0;
        end else if (w_en) begin
            r_out_vld <= w_vld_fin;
            r_y       <= w_vld_fin & resolve(w_dec_fin);
        end
    end

    assign bus.out_valid = r_out_vld;
    assign bus.y         = r_y;

`ifdef FCMP_NAN_EN
    logic r_unord;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_unord <= 1'b0;
        else if (w_en)
            r_unord <= w_vld_fin & w_dec_fin.un;
    end

    assign bus.unord = r_unord;
`else
    assign bus.unord = 1'b0;
`endif
endmodule

// File: tb/tb_fcmp_pipe.sv
// Bench for fcmp_pipe: default 32-bit build plus a 64-bit STAGES=3 build, checked against an ordering-key model.
module tb_fcmp_pipe;
    localparam int EW      = 8;
    localparam int MW      = 23;
    localparam int STAGES  = 2;
    localparam int EW2     = 11;
    localparam int MW2     = 52;
    localparam int STAGES2 = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fcmp_pipe_if #(.EW(EW),  .MW(MW))  bus  ();
    fcmp_pipe_if #(.EW(EW2), .MW(MW2)) bus2 ();

    fcmp_pipe #(.EW(EW), .MW(MW), .STAGES(STAGES)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    fcmp_pipe #(.EW(EW2), .MW(MW2), .STAGES(STAGES2)) u_dut2 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus2)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    int         n_ret       = 0;
    logic       rnd_ready   = 1'b0;
    logic [1:0] sb_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Map an operand onto a signed integer whose natural order is the float order after flush-to-zero.
    function automatic longint order_key(input int ew, input int mw, input logic [63:0] x);
        logic [63:0] em;
        em = x & ((64'd1 << (ew + mw)) - 64'd1);
        if ((em >> mw) == 64'd0)
            return 0;
        return x[ew+mw] ? -longint'(em) : longint'(em);
    endfunction

`ifdef FCMP_NAN_EN
    function automatic logic is_nan_m(input int ew, input int mw, input logic [63:0] x);
        logic [63:0] e;
        logic [63:0] m;
        e = (x >> mw) & ((64'd1 << ew) - 64'd1);
        m = x & ((64'd1 << mw) - 64'd1);
        return (e == ((64'd1 << ew) - 64'd1)) && (m != 64'd0);
    endfunction
`endif

    // Returns {y, unord}.
    function automatic logic [1:0] ref_cmp(input int ew, input int mw, input logic [1:0] op,
                                           input logic [63:0] a, input logic [63:0] b);
        longint ka;
        longint kb;
        logic   y;
        logic   un;
        ka = order_key(ew, mw, a);
        kb = order_key(ew, mw, b);
        case (op)
            2'd0:    y = (ka < kb);
            2'd1:    y = (ka <= kb);
            2'd2:    y = (ka == kb);
            default: y = 1'b0;
        endcase
        un = 1'b0;
`ifdef FCMP_NAN_EN
        if (op != 2'd3 && (is_nan_m(ew, mw, a) || is_nan_m(ew, mw, b))) begin
            y  = 1'b0;
            un = 1'b1;
        end
`endif
        return {y, un};
    endfunction

    function automatic logic [31:0] rand_operand();
        logic        s;
        logic [22:0] m;
        s = 1'($urandom_range(0, 1));
        m = 23'($urandom);
        case ($urandom_range(0, 7))
            0:       return {s, 31'd0};
            1:       return {s, 8'd0, m};
            2:       return {s, 8'hFF, 23'd0};
            3:       return {s, 8'hFF, m | 23'd1};
            4:       return {s, 8'($urandom_range(126, 128)), m};
            default: return $urandom;
        endcase
    endfunction

    // Present one beat, hold it until accepted, and record its expected result.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int guard;
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.x1       = a;
        bus.x2       = b;
        guard        = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb_q.push_back(ref_cmp(EW, MW, op, {32'd0, a}, {32'd0, b}));
                break;
            end
            guard++;
            if (guard > 100) begin
                check("send_timeout", {63'd0, bus.in_ready}, 64'd1);
                break;
            end
            @(posedge clk); #1;
            if (rnd_ready)
                bus.out_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (rnd_ready)
            bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wait_lat(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain();
        int guard;
        guard         = 0;
        rnd_ready     = 1'b0;
        bus.out_ready = 1'b1;
        while (sb_q.size() != 0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
        repeat (4) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send2_check(input string tag, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        int lat;
        bus2.in_valid = 1'b1;
        bus2.op       = op;
        bus2.x1       = a;
        bus2.x2       = b;
        @(negedge clk);
        check({tag, "_in_ready"}, {63'd0, bus2.in_ready}, 64'd1);
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        lat = 1;
        while (!bus2.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(STAGES2));
        check({tag, "_res"}, {62'd0, bus2.y, bus2.unord}, {62'd0, ref_cmp(EW2, MW2, op, a, b)});
    endtask

    // Output monitor: retire beats in order and require a stalled beat to hold still.
    initial begin : mon
        logic       prev_stall;
        logic [1:0] prev_out;
        logic [1:0] exp;
        prev_stall = 1'b0;
        prev_out   = 2'b00;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("hold_stable", {61'd0, bus.out_valid, bus.y, bus.unord}, {61'd0, 1'b1, prev_out});
                if (bus.out_valid && bus.out_ready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_beat", {63'd0, bus.out_valid}, 64'd0);
                    end else begin
                        exp = sb_q.pop_front();
                        check("result", {62'd0, bus.y, bus.unord}, {62'd0, exp});
                        n_ret++;
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_out   = {bus.y, bus.unord};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end of the sequence");
        $fatal(1);
    end

    initial begin : main
        int          lat;
        int          base;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] bp_a [6];
        logic [31:0] bp_b [6];

        bus.in_valid   = 1'b0;
        bus.op         = 2'd0;
        bus.x1         = '0;
        bus.x2         = '0;
        bus.out_ready  = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.op        = 2'd0;
        bus2.x1        = '0;
        bus2.x2        = '0;
        bus2.out_ready = 1'b1;
        rstn           = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_y",         {63'd0, bus.y},         64'd0);
        check("rst_unord",     {63'd0, bus.unord},     64'd0);
        check("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);

        @(posedge clk); #1;
        rstn = 1'b1;
        send(2'd0, 32'h3F800000, 32'h40000000);
        wait_lat(lat);
        check("lat_lt", 64'(lat), 64'(STAGES));

        send(2'd0, 32'h40000000, 32'h3F800000);
        send(2'd1, 32'h3F800000, 32'h3F800000);
        send(2'd2, 32'h80000000, 32'h00000001);
        send(2'd0, 32'h80000000, 32'h00000001);
        send(2'd0, 32'hBF800000, 32'h00400000);
        send(2'd0, 32'h3F800000, 32'h7FC00000);
        send(2'd3, 32'h3F800000, 32'h40000000);
        send(2'd3, 32'h7FC00000, 32'h3F800000);
        send(2'd0, 32'hFF800000, 32'hBF800000);
        send(2'd1, 32'hC0000000, 32'hBF800000);
        drain();

        rnd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = rand_operand();
            b  = rand_operand();
            case ($urandom_range(0, 7))
                0:       b = a;
                1:       b = a ^ 32'h80000000;
                default: ;
            endcase
            send(op, a, b);
        end
        drain();

        for (int i = 0; i < 6; i++) begin
            bp_a[i] = rand_operand();
            bp_b[i] = rand_operand();
        end
        base = n_ret;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(2'(i % 3), bp_a[i], bp_b[i]);
            end
            begin
                repeat (2) begin
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b0;
                repeat (5) begin
                    @(posedge clk); #1;
                end
                @(negedge clk);
                check("bp_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", 64'(n_ret - base), 64'd6);

        bus.out_ready = 1'b1;
        send(2'd0, 32'h3F800000, 32'h40000000);
        send(2'd1, 32'h3F800000, 32'h3F800000);
        rstn = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("midrst_y",         {63'd0, bus.y},         64'd0);
        check("midrst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        sb_q.delete();
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("midrst_hold_out_valid", {63'd0, bus.out_valid}, 64'd0);
        rstn = 1'b1;
        base = n_ret;
        send(2'd2, 32'h3F800000, 32'h3F800000);
        wait_lat(lat);
        check("midrst_lat", 64'(lat), 64'(STAGES));
        drain();
        check("midrst_count", 64'(n_ret - base), 64'd1);

        send2_check("d64_lt_neg",  2'd0, 64'hC000000000000000, 64'hBFF0000000000000);
        send2_check("d64_lt_swap", 2'd0, 64'hBFF0000000000000, 64'hC000000000000000);
        send2_check("d64_eq_zero", 2'd2, 64'h8000000000000000, 64'h0000000000000001);
        send2_check("d64_le_eq",   2'd1, 64'h3FF0000000000000, 64'h3FF0000000000000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
